// File: rtl/board_pkg.sv
// Shared types and constants for the board RAM write engine.
package board_pkg;

    typedef logic [3:0] block_type_t;

    typedef enum logic [1:0] {
        WRITE = 2'd0,
        SWAP  = 2'd1,
        FILL  = 2'd2,
        NOP   = 2'd3
    } cmd_op_t;

    localparam int BOARD_W     = 32;
    localparam int BOARD_H     = 24;
    localparam int BOARD_CELLS = 768;

    localparam block_type_t PELLET_TYPE = 4'd1;
    localparam block_type_t EMPTY_TYPE  = 4'd0;

    // One queued tile-update command.
    typedef struct packed {
        cmd_op_t     op;
        logic [4:0]  x;
        logic [4:0]  y;
        block_type_t typ;
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_WAIT,
        ST_SWAP_WR,
        ST_FILL
    } wr_state_t;

    // Rows are 32 tiles wide, so the linear address is just {row, column}.
    function automatic logic [9:0] tile_addr(input logic [4:0] x, input logic [4:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/board_cmd_fifo.sv
// Command FIFO in front of the board writer. Head entry is visible on
// o_dout while non-empty; o_ready is a registered "not full" so the
// producer sees a clean, glitch-free ready.
module board_cmd_fifo
    import board_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_push,
    input  cmd_t        i_din,
    input  logic        i_pop,
    output cmd_t        o_dout,
    output logic        o_full,
    output logic        o_empty,
    output logic        o_ready,
    output logic [AW:0] o_count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t          r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_ready;
    logic [AW:0]   w_count_nxt;

    // Occupancy after this cycle's push/pop; drives the registered ready.
    always_comb begin
        w_count_nxt = r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
    end

    // Entry storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // Pointers, count and ready; ready stays low for the whole reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ready <= 1'b0;
        end else begin
            if (i_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != FULL_CNT);
        end
    end

    assign o_dout  = r_mem[r_rptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_ready = r_ready;
    assign o_count = r_count;

endmodule

// File: rtl/board_writer.sv
// Write-side engine for the 32x24 tile board RAM: queues game-logic
// commands and performs WRITE, SWAP (read old type, write new) and FILL.
// Optional: define BOARD_WRITER_SCORE_EN to add the pellet_count output.
module board_writer
    import board_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int RD_LAT  = 2,
    parameter int BOARD_W = 32,
    parameter int BOARD_H = 24
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_x,
    input  logic [4:0]  cmd_y,
    input  logic [3:0]  cmd_type,
    output logic        rsp_valid,
    output logic [3:0]  rsp_type,
    output logic [9:0]  ram_address,
    output logic [3:0]  ram_data,
    output logic        ram_wren,
    input  logic [3:0]  ram_q,
    output logic        busy
`ifdef BOARD_WRITER_SCORE_EN
    ,
    output logic [9:0]  pellet_count
`endif
);

    localparam int          WW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [4:0]  Y_LIM     = 5'(BOARD_H);
    localparam logic [9:0]  FILL_LAST = 10'(BOARD_W * BOARD_H - 1);

    cmd_t                  w_push_cmd;
    cmd_t                  w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_ready;
    logic [$clog2(DEPTH):0] w_count;
    logic                  w_oor;
    logic                  w_rd_last;

    wr_state_t             r_state;
    wr_state_t             w_next;
    logic [9:0]            r_addr;      // also serves as the fill counter
    block_type_t           r_data;
    block_type_t           r_rsp_type;
    logic                  r_oor;
    logic [WW-1:0]         r_wait;

    // Pack the incoming command for the FIFO.
    always_comb begin
        w_push_cmd     = '0;
        w_push_cmd.op  = cmd_op_t'(cmd_op);
        w_push_cmd.x   = cmd_x;
        w_push_cmd.y   = cmd_y;
        w_push_cmd.typ = cmd_type;
    end

    assign w_push    = cmd_valid & cmd_ready & ~w_full;
    assign cmd_ready = w_ready;
    assign w_oor     = (w_head.y >= Y_LIM);
    assign w_rd_last = (r_wait == WW'(RD_LAT - 1));

    board_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (CLOCK_50),
        .i_rst_n (reset_n),
        .i_push  (w_push),
        .i_din   (w_push_cmd),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_ready (w_ready),
        .o_count (w_count)
    );

    // State register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    // Next-state, FIFO pop and RAM/response strobes.
    always_comb begin
        w_next    = r_state;
        w_pop     = 1'b0;
        ram_wren  = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    case (w_head.op)
                        WRITE:   w_next = w_oor ? ST_IDLE : ST_WR;
                        SWAP:    w_next = ST_RD_WAIT;
                        FILL:    w_next = ST_FILL;
                        default: w_next = ST_IDLE;
                    endcase
                end
            end
            ST_WR: begin
                ram_wren = 1'b1;
                w_next   = ST_IDLE;
            end
            ST_RD_WAIT: begin
                if (w_rd_last) w_next = ST_SWAP_WR;
            end
            ST_SWAP_WR: begin
                // An off-board SWAP still answers, but must not touch RAM.
                ram_wren  = ~r_oor;
                rsp_valid = 1'b1;
                w_next    = ST_IDLE;
            end
            ST_FILL: begin
                ram_wren = 1'b1;
                if (r_addr == FILL_LAST) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        busy = (w_count != '0) || (r_state != ST_IDLE);
    end

    // Address/data/response registers; address and data hold while idle.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_addr     <= '0;
            r_data     <= EMPTY_TYPE;
            r_rsp_type <= EMPTY_TYPE;
            r_oor      <= 1'b0;
            r_wait     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_wait <= '0;
                        r_oor  <= w_oor;
                        case (w_head.op)
                            WRITE, SWAP: begin
                                if (!w_oor) begin
                                    r_addr <= tile_addr(w_head.x, w_head.y);
                                    r_data <= w_head.typ;
                                end
                            end
                            FILL: begin
                                r_addr <= '0;
                                r_data <= w_head.typ;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RD_WAIT: begin
                    r_wait <= r_wait + WW'(1);
                    if (w_rd_last) r_rsp_type <= r_oor ? EMPTY_TYPE : ram_q;
                end
                ST_FILL: begin
                    if (r_addr != FILL_LAST) r_addr <= r_addr + 10'd1;
                end
                default: ;
            endcase
        end
    end

    assign ram_address = r_addr;
    assign ram_data    = r_data;
    assign rsp_type    = r_rsp_type;

`ifdef BOARD_WRITER_SCORE_EN
    logic [9:0] r_pellets;

    // Count pellets eaten by SWAPs; a FILL starts a fresh level at zero.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_pellets <= '0;
        end else if (r_state == ST_FILL && r_addr == 10'd0) begin
            r_pellets <= '0;
        end else if (r_state == ST_SWAP_WR && r_rsp_type == PELLET_TYPE &&
                     r_data != PELLET_TYPE && r_pellets != 10'h3FF) begin
            r_pellets <= r_pellets + 10'd1;
        end
    end

    assign pellet_count = r_pellets;
`endif

endmodule

// File: tb/tb_board_writer.sv
// Bench for board_writer: directed scenarios plus random commands, checked
// every cycle against a command-level model (FIFO of commands expanded into
// per-cycle RAM actions at dispatch).
module tb_board_writer;

    localparam int DEPTH  = 4;
    localparam int RD_LAT = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [4:0] cmd_x = 5'd0;
    logic [4:0] cmd_y = 5'd0;
    logic [3:0] cmd_type = 4'd0;
    logic       rsp_valid;
    logic [3:0] rsp_type;
    logic [9:0] ram_address;
    logic [3:0] ram_data;
    logic       ram_wren;
    logic [3:0] ram_q;
    logic       busy;
`ifdef BOARD_WRITER_SCORE_EN
    logic [9:0] pellet_count;
`endif

    board_writer #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .BOARD_W(32), .BOARD_H(24)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_x       (cmd_x),
        .cmd_y       (cmd_y),
        .cmd_type    (cmd_type),
        .rsp_valid   (rsp_valid),
        .rsp_type    (rsp_type),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .busy        (busy)
`ifdef BOARD_WRITER_SCORE_EN
        ,
        .pellet_count(pellet_count)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Board RAM: registered read, write port driven by the DUT.
    logic [3:0] ram [0:1023];
    logic       ram_clr = 1'b0;
    logic       pl_en = 1'b0;
    logic [9:0] pl_addr = 10'd0;
    logic [3:0] pl_data = 4'd0;
    always @(posedge CLOCK_50) begin
        if (ram_clr) for (int i = 0; i < 1024; i++) ram[i] <= 4'd0;
        else if (pl_en) ram[pl_addr] <= pl_data;
        else if (ram_wren) ram[ram_address] <= ram_data;
        ram_q <= ram[ram_address];
    end

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0] op; logic [4:0] x; logic [4:0] y; logic [3:0] t;
    } cmd_s;
    typedef struct packed {
        logic wren; logic [9:0] addr; logic [3:0] data; logic setad;
        logic rsp; logic [3:0] old; logic clr; logic pel;
    } act_s;

    cmd_s       fq[$];
    act_s       aq[$];
    logic [3:0] mmem [0:1023];
    logic [9:0] exp_addr = '0;
    logic [3:0] exp_data = '0;
    logic [3:0] exp_rt = '0;
    int         exp_pel = 0;
    bit         rst_prev = 1'b1;
    bit         e_ready = 1'b0;
    bit         acc = 1'b0;

    int n_chk = 0, n_fail = 0, cyc = 0, acc_cyc = 0;
    int n_wr = 0, n_rsp = 0, rsp_cyc = 0, fill_idx = 0, fill_bad = 0;
    bit fill_mon = 1'b0;
    logic [9:0] last_wa;
    logic [3:0] last_wd, last_rt;
    logic       s_ready, s_busy, s_wren;
    logic [9:0] s_addr, s_pel;
    logic [3:0] s_data, s_rt;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic dispatch();
        cmd_s c;
        act_s n;
        int   a;
        bit   oor;
        c   = fq.pop_front();
        a   = int'(c.y) * 32 + int'(c.x);
        oor = (c.y >= 5'd24);
        n   = '0;
        case (c.op)
            2'd0: if (!oor) begin
                exp_addr = 10'(a); exp_data = c.t;
                n.wren = 1'b1; n.addr = 10'(a); n.data = c.t;
                aq.push_back(n);
            end
            2'd1: begin
                if (!oor) begin exp_addr = 10'(a); exp_data = c.t; end
                for (int i = 0; i < RD_LAT; i++) aq.push_back(n);
                n.wren = !oor; n.addr = 10'(a); n.data = c.t; n.rsp = 1'b1;
                n.old  = oor ? 4'd0 : mmem[a];
                n.pel  = (n.old == 4'd1) && (c.t != 4'd1);
                aq.push_back(n);
            end
            2'd2: begin
                exp_addr = '0; exp_data = c.t;
                for (int i = 0; i < 768; i++) begin
                    n = '0; n.wren = 1'b1; n.addr = 10'(i); n.data = c.t;
                    n.setad = 1'b1; n.clr = (i == 0);
                    aq.push_back(n);
                end
            end
            default: ;
        endcase
    endtask

    // Per-cycle check of every DUT output (skipped while reset is asserted).
    task automatic compare();
        bit e_busy, e_wren, e_rsp;
        s_ready = cmd_ready; s_busy = busy; s_wren = ram_wren;
        s_addr = ram_address; s_data = ram_data; s_rt = rsp_type; s_pel = '0;
`ifdef BOARD_WRITER_SCORE_EN
        s_pel = pellet_count;
`endif
        if (ram_wren === 1'b1) begin
            n_wr++; last_wa = ram_address; last_wd = ram_data;
            if (fill_mon) begin
                if (ram_address !== 10'(fill_idx)) fill_bad++;
                fill_idx++;
            end
        end
        if (rsp_valid === 1'b1) begin n_rsp++; last_rt = rsp_type; rsp_cyc = cyc; end
        if (reset_n !== 1'b1) return;
        e_ready = !rst_prev && (fq.size() < DEPTH);
        e_busy  = (fq.size() > 0) || (aq.size() > 0);
        e_wren  = (aq.size() > 0) && aq[0].wren;
        e_rsp   = (aq.size() > 0) && aq[0].rsp;
        if (e_rsp) exp_rt = aq[0].old;
        if (aq.size() > 0 && aq[0].setad) exp_addr = aq[0].addr;
        chk("cmd_ready", cmd_ready, e_ready);
        chk("busy", busy, e_busy);
        chk("ram_wren", ram_wren, e_wren);
        chk("rsp_valid", rsp_valid, e_rsp);
        chk("ram_address", ram_address, exp_addr);
        chk("ram_data", ram_data, exp_data);
        chk("rsp_type", rsp_type, exp_rt);
`ifdef BOARD_WRITER_SCORE_EN
        chk("pellet_count", pellet_count, exp_pel);
`endif
    endtask

    // Advance the model over one rising edge.
    task automatic update();
        act_s a;
        cmd_s c;
        acc = 1'b0;
        if (reset_n !== 1'b1) begin
            // The write in flight during the reset cycle still reaches the RAM.
            if (aq.size() > 0 && aq[0].wren) mmem[aq[0].addr] = aq[0].data;
            fq.delete(); aq.delete();
            exp_addr = '0; exp_data = '0; exp_rt = '0; exp_pel = 0; rst_prev = 1'b1;
            return;
        end
        acc = cmd_valid && e_ready;
        if (aq.size() > 0) begin
            a = aq.pop_front();
            if (a.wren) mmem[a.addr] = a.data;
            if (a.clr) exp_pel = 0;
            else if (a.pel && exp_pel < 1023) exp_pel++;
        end else if (fq.size() > 0) begin
            dispatch();
        end
        if (acc) begin
            c.op = cmd_op; c.x = cmd_x; c.y = cmd_y; c.t = cmd_type;
            fq.push_back(c);
        end
        rst_prev = 1'b0;
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        cyc++;
        compare();
        @(posedge CLOCK_50);
        update();
        #1;
    endtask

    task automatic send(input int op, input int x, input int y, input int t);
        bit got = 1'b0;
        cmd_op = 2'(op); cmd_x = 5'(x); cmd_y = 5'(y); cmd_type = 4'(t);
        cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !got; i++) begin
            tick();
            if (acc) begin got = 1'b1; acc_cyc = cyc; end
        end
        cmd_valid = 1'b0;
        chk("send_accepted", got, 1);
    endtask

    task automatic wait_idle(input int limit);
        int i = 0;
        while ((fq.size() > 0 || aq.size() > 0) && i < limit) begin tick(); i++; end
        tick();
        chk("wait_idle_in_time", (i < limit), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accs [5];
        for (int i = 0; i < 1024; i++) mmem[i] = 4'd0;

        // Reset with RAM clear.
        ram_clr = 1'b1; tick(); ram_clr = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_ready", s_ready, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_wren", s_wren, 0);
        chk("rst_addr", s_addr, 0);
        tick();
        chk("ready_after_rst", s_ready, 1);

        // Plain WRITE x=3 y=2 type=5 -> addr 67.
        n_wr = 0;
        send(0, 3, 2, 5);
        wait_idle(50);
        chk("write_count", n_wr, 1);
        chk("write_addr", last_wa, 67);
        chk("write_data", last_wd, 5);
        chk("write_busy_done", s_busy, 0);

        // SWAP on a pellet tile.
        pl_en = 1'b1; pl_addr = 10'd67; pl_data = 4'd1; mmem[67] = 4'd1;
        tick(); pl_en = 1'b0;
        n_wr = 0; n_rsp = 0;
        send(1, 3, 2, 0);
        wait_idle(50);
        chk("swap_rsp_count", n_rsp, 1);
        chk("swap_rsp_type", last_rt, 1);
        chk("swap_rsp_latency", rsp_cyc - acc_cyc, 1 + RD_LAT + 1);
        chk("swap_write_count", n_wr, 1);
        chk("swap_write_addr", last_wa, 67);
        chk("swap_write_data", last_wd, 0);
`ifdef BOARD_WRITER_SCORE_EN
        chk("swap_pellet", s_pel, 1);
`endif

        // FILL with pellets.
        n_wr = 0; fill_mon = 1'b1; fill_idx = 0; fill_bad = 0;
        send(2, 0, 0, 1);
        wait_idle(1000);
        fill_mon = 1'b0;
        chk("fill_writes", n_wr, 768);
        chk("fill_order_errors", fill_bad, 0);
        chk("fill_last_data", last_wd, 1);

        // Five back-to-back commands behind a FILL.
        send(2, 0, 0, 2);
        for (int j = 0; j < 5; j++) begin
            send(0, j, j, j + 3);
            accs[j] = acc_cyc;
        end
        chk("four_accepts_back_to_back", accs[3] - accs[0], 3);
        chk("fifth_held_until_fill_ends", (accs[4] - accs[3]) > 700, 1);
        wait_idle(200);
        chk("queued_last_addr", last_wa, 132);
        chk("queued_last_data", last_wd, 7);

        // Off-board commands.
        n_wr = 0; n_rsp = 0;
        send(0, 0, 24, 6);
        send(1, 1, 30, 7);
        wait_idle(50);
        chk("oor_no_write", n_wr, 0);
        chk("oor_swap_rsp", n_rsp, 1);
        chk("oor_swap_type", last_rt, 0);

        // Reset in the middle of a FILL at counter 100.
        fill_mon = 1'b1; fill_idx = 0;
        send(2, 0, 0, 3);
        for (int i = 0; i < 300 && fill_idx < 100; i++) tick();
        fill_mon = 1'b0;
        chk("fill_reached_100", fill_idx, 100);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_wr = 0;
        tick();
        chk("midrst_ready", s_ready, 0);
        chk("midrst_wren", s_wren, 0);
        chk("midrst_addr", s_addr, 0);
        chk("midrst_data", s_data, 0);
        chk("midrst_rsp_type", s_rt, 0);
        repeat (4) tick();
        chk("midrst_no_writes", n_wr, 0);
        chk("midrst_ready_back", s_ready, 1);
        chk("midrst_busy", s_busy, 0);
        send(0, 5, 1, 9);
        wait_idle(50);
        chk("post_rst_write_addr", last_wa, 37);
        chk("post_rst_write_data", last_wd, 9);

        // Random traffic.
        for (int k = 0; k < 250; k++) begin
            int r, op, x, y, t;
            r  = $urandom_range(0, 99);
            op = (r < 45) ? 0 : (r < 85) ? 1 : (r < 89) ? 2 : 3;
            x  = $urandom_range(0, 7);
            y  = $urandom_range(0, 25);
            t  = $urandom_range(0, 1) ? $urandom_range(0, 2) : $urandom_range(0, 15);
            repeat ($urandom_range(0, 2)) tick();
            send(op, x, y, t);
        end
        wait_idle(5000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write-side engine for the 32x24 tile board RAM. The video path only reads this RAM.
- Accepts tile-update commands from game logic (Pac-Man movement, pellet eating, level reset) through a valid/ready handshake.
- Buffers commands in a small FIFO and drives the board RAM write port.
- Supports plain writes, read-then-write swaps that return the old tile type, and whole-board fills.

Parameters:
- DEPTH, 4: command FIFO entries; must be a power of 2, at least 2.
- RD_LAT, 2: cycles from ram_address valid to ram_q valid.
- BOARD_W, 32: tiles per row.
- BOARD_H, 24: tile rows.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  2  0=WRITE, 1=SWAP, 2=FILL, 3=reserved (treated as a no-op).
- cmd_x  in  5  tile column, 0..31.
- cmd_y  in  5  tile row, 0..23.
- cmd_type  in  4  new block type.
- rsp_valid  out  1  one-cycle pulse carrying a SWAP result.
- rsp_type  out  4  old block type read by a SWAP.
- ram_address  out  10  board RAM address.
- ram_data  out  4  board RAM write data.
- ram_wren  out  1  board RAM write enable.
- ram_q  in  4  board RAM read data.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous and active-low (reset_n, sampled on the rising edge of CLOCK_50).
  - While reset_n=0: FIFO emptied, FSM forced to IDLE.
  - Outputs forced to cmd_ready=0, rsp_valid=0, rsp_type=0, ram_address=0, ram_data=0, ram_wren=0, busy=0.
  - cmd_ready goes to 1 in the first cycle after reset_n rises.
- Reset mid-operation: a FILL or SWAP in progress is abandoned with no further writes, and queued commands are lost.
- Handshake and FIFO:
  - Accept on cmd_valid & cmd_ready. cmd_ready = !full, registered from the FIFO count.
  - A push and a pop in the same cycle are legal; count is unchanged.
  - While full, cmd_valid is ignored and the caller must hold its command.
- Address: ram_address = cmd_y*32 + cmd_x, i.e. {cmd_y, cmd_x}; valid range 0..767.
  - Commands with cmd_y >= 24 are out of range: popped with no RAM write.
  - An out-of-range SWAP still pulses rsp_valid, with rsp_type=0.
- FSM states: IDLE, WR, RD_WAIT, SWAP_WR, FILL.
  - IDLE: if the FIFO is non-empty, pop the head and dispatch it: WRITE goes to WR, SWAP goes to RD_WAIT, FILL goes to FILL with counter=0, reserved goes back to IDLE.
  - WR: one cycle with ram_wren=1, address/data from the command; then IDLE.
  - RD_WAIT: ram_wren=0 and address held for RD_LAT cycles. On the last cycle ram_q is captured into rsp_type; go to SWAP_WR.
  - SWAP_WR: ram_wren=1 with cmd_type, and rsp_valid=1 for exactly this cycle; then IDLE.
  - FILL: ram_wren=1, ram_address=counter, ram_data=cmd_type. Counter increments 0..767, one write per cycle, 768 cycles total; on 767, go to IDLE.
- Latency:
  - Accept to first RAM write, empty FIFO: WRITE = 2 cycles (FIFO register plus the IDLE dispatch).
  - SWAP write occurs RD_LAT+1 cycles after dispatch.
- The FSM is non-pipelined: one command in flight at a time. Commands complete in FIFO order.
- ram_wren is 0 in IDLE and RD_WAIT. ram_address and ram_data hold their last values when idle.
- rsp_type holds its value between pulses.

Optional Feature:
- Macro: BOARD_WRITER_SCORE_EN.
- Defined:
  - Adds output port pellet_count [9:0], reset to 0.
  - Increments by 1 in every SWAP_WR cycle where the captured old type equals PELLET_TYPE and cmd_type differs from it.
  - Saturates at 1023.
  - A FILL clears it to 0 in its first cycle.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package board_pkg:
  - Typedef block_type_t (logic [3:0]).
  - Enum cmd_op_t: WRITE, SWAP, FILL, NOP.
  - Constants BOARD_W=32, BOARD_H=24, BOARD_CELLS=768, PELLET_TYPE=4'd1, EMPTY_TYPE=4'd0.
- Sub-module board_cmd_fifo: synchronous FIFO with DEPTH entries holding {op, x, y, type}; provides full/empty/count.
- The FSM and fill counter stay in board_writer.

Test Plan:
- Reset then WRITE x=3, y=2, type=5: exactly one cycle of ram_wren=1 with ram_address=67, ram_data=5; busy returns to 0.
- RAM model preloaded with addr 67 = 1, then SWAP x=3, y=2, type=0:
  - rsp_valid pulses once with rsp_type=1, RD_LAT+1 cycles after dispatch.
  - Next write: addr 67 with data 0.
  - With SCORE_EN, pellet_count=1.
- FILL type=1: 768 consecutive write cycles, addresses 0..767 in order, all data=1; cmd_ready stays high until the FIFO fills.
- Push 5 commands back-to-back with DEPTH=4 during a FILL:
  - cmd_ready drops after 4 accepts.
  - The 5th is held and accepted after the first pop.
  - All execute in order.
- WRITE with y=24, x=0: popped, no ram_wren. SWAP with y=30: rsp_valid with rsp_type=0 and no write.
- reset_n low for 1 cycle at fill counter 100: no writes afterwards, FIFO empty, all outputs at reset values, next command executes normally.
